// File: rtl/uni_shift_reg_n.sv
// uni_shift_reg_n: multi-step universal shift register with IDLE/RUN/DONE sequencing; define USR_ROTATE_EN to enable rotate modes 100/101.
module uni_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] par_in,
    input  logic             serial_in_l,
    input  logic             serial_in_r,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out_l,
    output logic             serial_out_r,
    output logic             busy,
    output logic             done
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]       state;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] rem;
    logic [2:0]       m;
    logic [WIDTH-1:0] rol, ror, nxt;
    logic             rot_en, accept, shifting, multi;
`ifdef USR_ROTATE_EN
    assign rot_en = 1'b1;
    assign rol    = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
    assign ror    = {data_out[0], data_out[WIDTH-1:1]};
`else
    assign rot_en = 1'b0;
    assign rol    = data_out;
    assign ror    = data_out;
`endif
    assign accept   = start && (state == IDLE || state == DONE);
    // The step on the acceptance edge uses the incoming mode; later steps use the captured one.
    assign m        = accept ? mode : mode_q;
    assign shifting = m == 3'b001 || m == 3'b010 || m == 3'b110 || (rot_en && (m == 3'b100 || m == 3'b101));
    assign multi    = shifting && count > CNT_W'(1);
    always_comb
        nxt = m == 3'b001 ? {data_out[WIDTH-2:0], serial_in_l} :
              m == 3'b010 ? {serial_in_r, data_out[WIDTH-1:1]} :
              m == 3'b011 ? par_in :
              m == 3'b100 ? rol :
              m == 3'b101 ? ror :
              m == 3'b110 ? {data_out[WIDTH-1], data_out[WIDTH-1:1]} :
              m == 3'b111 ? '0 : data_out;
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            state    <= IDLE;
            rem      <= '0;
            mode_q   <= '0;
        end else if (accept) begin
            data_out <= nxt;
            mode_q   <= mode;
            state    <= multi ? RUN : DONE;
            rem      <= multi ? count - 1'b1 : '0;
        end else if (state == RUN) begin
            data_out <= nxt;
            rem      <= rem - 1'b1;
            state    <= rem == CNT_W'(1) ? DONE : RUN;
        end else begin
            state    <= IDLE;
        end
    end
    assign serial_out_l = data_out[WIDTH-1];
    assign serial_out_r = data_out[0];
    assign busy         = state == RUN;
    assign done         = state == DONE;
endmodule

// File: tb/tb_uni_shift_reg_n.sv
// tb_uni_shift_reg_n: directed and randomized operations checked against an operation-level arithmetic model.
module tb_uni_shift_reg_n;
`ifdef USR_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif
    logic       clk = 1'b0, reset, start, serial_in_l, serial_in_r;
    logic [2:0] mode;
    logic [3:0] count;
    logic [7:0] par_in, data_out, exp_d;
    logic       serial_out_l, serial_out_r, busy, done;
    int         passed = 0, failed = 0, total = 0;

    uni_shift_reg_n #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .count(count),
        .par_in(par_in), .serial_in_l(serial_in_l), .serial_in_r(serial_in_r),
        .data_out(data_out), .serial_out_l(serial_out_l), .serial_out_r(serial_out_r),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_step(input logic [2:0] md, input logic [7:0] d, input logic [7:0] p,
                                            input logic sl, input logic sr);
        int v;
        v = d;
        case (md)
            3'd1: v = (v * 2 + sl) % 256;
            3'd2: v = v / 2 + sr * 128;
            3'd3: v = p;
            3'd4: v = ROT ? (v * 2 + v / 128) % 256 : v;
            3'd5: v = ROT ? v / 2 + (v % 2) * 128 : v;
            3'd6: v = v / 2 + (v / 128) * 128;
            3'd7: v = 0;
            default: ;
        endcase
        return v[7:0];
    endfunction

    task automatic check_outs(input string tag, input logic b, input logic d);
        chk({tag, " data"}, data_out, exp_d);
        chk({tag, " busy"}, busy, b);
        chk({tag, " done"}, done, d);
        chk({tag, " sout_l"}, serial_out_l, exp_d[7]);
        chk({tag, " sout_r"}, serial_out_r, exp_d[0]);
    endtask

    task automatic idle();
        start = 1'b0;
        mode  = 3'($urandom);
        @(negedge clk);
        check_outs("idle", 1'b0, 1'b0);
    endtask

    // Drives one operation starting at a negedge and checks every cycle up to the done pulse.
    task automatic do_op(input logic [2:0] md, input logic [3:0] cn, input logic [7:0] pv,
                         input logic sl, input logic sr, input bit vary);
        int n;
        bit sh;
        sh = md == 3'd1 || md == 3'd2 || md == 3'd6 || (ROT && (md == 3'd4 || md == 3'd5));
        n  = (sh && cn > 1) ? int'(cn) : 1;
        start = 1'b1; mode = md; count = cn; par_in = pv; serial_in_l = sl; serial_in_r = sr;
        for (int k = 0; k < n; k++) begin
            exp_d = ref_step(md, exp_d, pv, serial_in_l, serial_in_r);
            @(negedge clk);
            check_outs($sformatf("op m%0d c%0d s%0d", md, cn, k), k < n - 1, k == n - 1);
            start  = (k < n - 1) ? 1'($urandom) : 1'b0;
            mode   = 3'($urandom);
            count  = 4'($urandom);
            par_in = 8'($urandom);
            if (vary) begin
                serial_in_l = 1'($urandom);
                serial_in_r = 1'($urandom);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 3'd0; count = 4'd0; par_in = 8'd0;
        serial_in_l = 1'b0; serial_in_r = 1'b0; exp_d = 8'h00;
        @(negedge clk);
        check_outs("reset", 1'b0, 1'b0);
        reset = 1'b0;
        idle();
        do_op(3'd3, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("load lit", data_out, 8'hA5);
        idle();
        do_op(3'd1, 4'd3, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("shl lit", data_out, 8'h2F);
        idle();
        do_op(3'd3, 4'd0, 8'h80, 1'b0, 1'b0, 1'b0);
        do_op(3'd6, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("asr lit", data_out, 8'hE0);
        do_op(3'd3, 4'd0, 8'h80, 1'b0, 1'b0, 1'b0);
        idle();
        do_op(3'd2, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("lsr0 lit", data_out, 8'h40);
        idle();
        do_op(3'd3, 4'd0, 8'h81, 1'b0, 1'b0, 1'b0);
        idle();
        do_op(3'd4, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rol lit", data_out, ROT ? 8'h03 : 8'h81);
        idle();
        do_op(3'd5, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0);
        idle();
        // Abort a five-step shift with reset after two steps; no done pulse may follow.
        do_op(3'd3, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0);
        idle();
        start = 1'b1; mode = 3'd2; count = 4'd5; serial_in_r = 1'b0;
        @(negedge clk);
        chk("abort s1", data_out, 8'h7F);
        chk("abort busy1", busy, 1'b1);
        start = 1'b1; mode = 3'd7;
        @(negedge clk);
        chk("abort s2", data_out, 8'h3F);
        chk("abort busy2", busy, 1'b1);
        start = 1'b0; reset = 1'b1;
        @(negedge clk);
        exp_d = 8'h00;
        check_outs("abort rst", 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_outs("abort after", 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(1, 0) == 1) idle();
            do_op(3'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uni_shift_reg_n.md
UNI_SHIFT_REG_N -- requirements
Module: uni_shift_reg_n

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, register width in bits (>=2).
REQ-002 SHALL have parameter: CNT_W, default 4, width of the step-count input.
REQ-003 SHALL have port: clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  operation request; sampled only in IDLE or DONE.
REQ-006 SHALL have port: mode  input  3  operation code, captured on acceptance.
REQ-007 SHALL have port: count  input  CNT_W  number of shift steps, captured on acceptance.
REQ-008 SHALL have port: par_in  input  WIDTH  parallel load data.
REQ-009 SHALL have port: serial_in_l  input  1  bit entering at the LSB on left shift.
REQ-010 SHALL have port: serial_in_r  input  1  bit entering at the MSB on logical right shift.
REQ-011 SHALL have port: data_out  output  WIDTH  register contents.
REQ-012 SHALL have port: serial_out_l / serial_out_r  output  1 each  data_out MSB / LSB.
REQ-013 SHALL have port: busy  output  1  high while in RUN.
REQ-014 SHALL have port: done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL decode mode as: 000 hold; 001 shift left; 010 logical shift right; 011 parallel load; 100 rotate left; 101 rotate right; 110 arithmetic shift right (MSB replicated); 111 clear to 0.
REQ-016 SHALL implement FSM IDLE, RUN, DONE; start is accepted on an edge where start=1 and state is IDLE or DONE.
REQ-017 SHALL execute the first step on the acceptance edge itself; hold/load/clear are single-step operations.
REQ-018 SHALL treat count=0 as 1 for the shifting modes (001, 010, 100, 101, 110).
REQ-019 SHALL, for a shifting mode with count N>=2, enter RUN with N-1 remaining steps, perform one step per edge, and leave RUN on the edge that performs the last step.
REQ-020 SHALL enter DONE after the last step of any operation; done=1 only in DONE; DONE returns to IDLE on the next edge unless a new start is accepted there.
REQ-021 SHALL sample the serial inputs on each step edge; captured mode/count SHALL NOT change while in RUN.
REQ-022 SHALL ignore start while in RUN, with no effect on data_out or the step count.
REQ-023 SHALL hold data_out unchanged in IDLE and DONE when no start is accepted.
REQ-024 SHALL take total latency of an N-step operation from the acceptance edge to done high as N edges (done high during the cycle after the last step).

Reset
REQ-025 SHALL, on an edge with reset=1, set data_out=0, busy=0, done=0, remaining count=0, state=IDLE, overriding start and any operation in progress.
REQ-026 SHALL NOT produce a done pulse for an operation aborted by reset.

Configuration
REQ-027 SHALL, when USR_ROTATE_EN is defined, implement modes 100/101 as rotate left/right.
REQ-028 SHALL, when USR_ROTATE_EN is undefined, execute modes 100/101 as single-step hold (data_out unchanged, done pulse after one edge, count ignored).

Verification (WIDTH=8, CNT_W=4)
REQ-029 SHALL cover: reset held 1 cycle -> data_out=0x00, busy=0, done=0.
REQ-030 SHALL cover: start, mode=011, par_in=0xA5 -> data_out=0xA5 next cycle, done=1 for one cycle, busy never high.
REQ-031 SHALL cover: from 0xA5, start, mode=001, count=3, serial_in_l=1 -> 0x4B, 0x97, 0x2F on successive edges; busy high 2 cycles; done pulse after 0x2F.
REQ-032 SHALL cover: from 0x80, mode=110, count=2 -> 0xC0 then 0xE0; from 0x80, mode=010, count=0, serial_in_r=0 -> 0x40 in one step.
REQ-033 SHALL cover: from 0x81, mode=100, count=1 -> 0x03 with USR_ROTATE_EN; 0x81 without it; done pulse in both builds.
REQ-034 SHALL cover: from 0xFF, mode=010, count=5, serial_in_r=0; start pulsed again in RUN (ignored); reset after 2 steps (data_out=0x3F) -> data_out=0x00, IDLE, no done pulse.
